// File: rtl/push_ctrl_pkg.sv
// push_ctrl_pkg: shared register map, debounce FSM states and counter width
package push_ctrl_pkg;
  localparam int CNT_W = 16;
  localparam logic [1:0] REG_DATA = 2'd0;
  localparam logic [1:0] REG_MASK = 2'd1;
  localparam logic [1:0] REG_EDGE = 2'd2;
  localparam logic [1:0] REG_CFG  = 2'd3;
  typedef enum logic {STABLE, COUNTING} deb_state_t;
endpackage

// File: rtl/push_debounce_ch.sv
// push_debounce_ch: one key: two-flop synchroniser, tick-counted debounce FSM, press pulse
module push_debounce_ch
  import push_ctrl_pkg::*;
#(
  parameter logic RESET_LEVEL = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_key,
  input  logic             i_tick,
  input  logic [CNT_W-1:0] i_cfg,
  output logic             o_deb,
  output logic             o_press
);
  logic             r_s1, r_s2, r_deb;
  deb_state_t       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             w_diff, w_fire;
  logic [CNT_W:0]   w_next;
  assign w_diff  = r_s2 != r_deb;
  assign w_next  = {1'b0, r_cnt} + 1'b1;
  // a zero period bypasses the count; otherwise resolve on the tick that reaches the period
  assign w_fire  = w_diff && (i_cfg == '0 || (r_state == COUNTING && i_tick && w_next >= {1'b0, i_cfg}));
  assign o_press = w_fire && r_deb && !r_s2;
  assign o_deb   = r_deb;
  // two-flop synchroniser for the raw key
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_s1 <= RESET_LEVEL;
      r_s2 <= RESET_LEVEL;
    end else begin
      r_s1 <= i_key;
      r_s2 <= r_s1;
    end
  // debounce FSM: count ticks while the synchronised level differs, drop back on a bounce
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_deb   <= RESET_LEVEL;
      r_state <= STABLE;
      r_cnt   <= '0;
    end else if (w_fire) begin
      r_deb   <= r_s2;
      r_state <= STABLE;
      r_cnt   <= '0;
    end else if (!w_diff) begin
      r_state <= STABLE;
      r_cnt   <= '0;
    end else if (r_state == STABLE) begin
      r_state <= COUNTING;
      r_cnt   <= '0;
    end else if (i_tick) begin
      r_cnt <= &r_cnt ? r_cnt : r_cnt + 1'b1;
    end
endmodule

// File: rtl/nios_system_push_ctrl.sv
// nios_system_push_ctrl: debounced four-key Avalon-MM slave with edge capture and maskable irq
module nios_system_push_ctrl
  import push_ctrl_pkg::*;
#(
  parameter int               TICK_DIV    = 50000,
  parameter logic [CNT_W-1:0] DEB_DEFAULT = 16'd20,
  parameter logic [3:0]       RESET_LEVEL = 4'hF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  input  logic [3:0]  in_port,
  output logic [31:0] readdata,
  output logic        irq,
  output logic [3:0]  key_level
);
  localparam int DIV_W = $clog2(TICK_DIV);
  logic [DIV_W-1:0] r_div;
  logic [3:0]       r_mask, r_edge, w_deb, w_press, w_clr;
  logic [CNT_W-1:0] r_cfg;
  logic             w_tick, w_wr, w_unused;
  assign w_tick    = r_div == DIV_W'(TICK_DIV - 1);
  assign w_wr      = chipselect && !write_n;
  assign w_clr     = (w_wr && address == REG_EDGE) ? writedata[3:0] : 4'h0;
  assign irq       = |(r_edge & r_mask);
  assign key_level = w_deb;
  assign w_unused  = ^writedata[31:16];
  // free-running prescaler producing the shared debounce tick
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) r_div <= '0;
    else r_div <= w_tick ? '0 : r_div + 1'b1;
  for (genvar i = 0; i < 4; i++) begin : g_ch
    push_debounce_ch #(.RESET_LEVEL(RESET_LEVEL[i])) u_ch (
      .clk    (clk),
      .reset_n(reset_n),
      .i_key  (in_port[i]),
      .i_tick (w_tick),
      .i_cfg  (r_cfg),
      .o_deb  (w_deb[i]),
      .o_press(w_press[i])
    );
  end
  // software registers; a new press outranks a simultaneous clear of the same bit
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_mask <= 4'h0;
      r_edge <= 4'h0;
      r_cfg  <= DEB_DEFAULT;
    end else begin
      if (w_wr && address == REG_MASK) r_mask <= writedata[3:0];
      if (w_wr && address == REG_CFG) r_cfg <= writedata[CNT_W-1:0];
      r_edge <= (r_edge & ~w_clr) | w_press;
    end
  // registered read mux, reloaded every cycle
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) readdata <= '0;
    else readdata <= address == REG_DATA ? {28'h0, w_deb} :
                     address == REG_MASK ? {28'h0, r_mask} :
                     address == REG_EDGE ? {28'h0, r_edge} : {16'h0, r_cfg};
endmodule

// File: tb/tb_nios_system_push_ctrl.sv
// tb_nios_system_push_ctrl: directed and random stimulus against a tick-counting reference model
module tb_nios_system_push_ctrl;
  localparam int TD = 4;
  logic        clk = 0, reset_n = 0, chipselect = 0, write_n = 1;
  logic [1:0]  address = 0;
  logic [31:0] writedata = 0;
  logic [3:0]  in_port = 4'hF;
  logic [31:0] readdata;
  logic        irq;
  logic [3:0]  key_level;
  int          checks = 0, errors = 0;
  bit          mon = 0;
  always #5 clk = ~clk;
  nios_system_push_ctrl #(.TICK_DIV(TD)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(readdata), .irq(irq), .key_level(key_level)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h at %0t", tag, got, exp, $time);
    end
  endtask
  // reference model: keys seen two edges late, resolved after cfg ticks of continuous disagreement
  logic [3:0]  m_q[2] = '{4'hF, 4'hF};
  logic [3:0]  m_deb = 4'hF, m_mask = 0, m_edge = 0, m_pressed, m_seen;
  logic [15:0] m_cfg = 16'd20;
  logic [31:0] m_rd = 0;
  bit          m_wait[4];
  int          m_ticks[4];
  int          k = 0;
  bit          m_tick;
  always @(posedge clk) begin
    if (!reset_n) begin
      m_q = '{4'hF, 4'hF}; m_deb = 4'hF; m_mask = 0; m_edge = 0; m_cfg = 16'd20; m_rd = 0; k = 0;
      for (int i = 0; i < 4; i++) m_wait[i] = 0;
    end else begin
      m_tick = (k % TD) == TD - 1;
      k++;
      m_rd = address == 0 ? {28'h0, m_deb} : address == 1 ? {28'h0, m_mask} :
             address == 2 ? {28'h0, m_edge} : {16'h0, m_cfg};
      m_seen = m_q[1];
      m_pressed = 0;
      for (int i = 0; i < 4; i++) begin
        if (m_seen[i] == m_deb[i]) m_wait[i] = 0;
        else if (m_cfg == 0 || (m_wait[i] && m_tick && m_ticks[i] + 1 >= int'(m_cfg))) begin
          m_pressed[i] = m_deb[i];
          m_deb[i] = m_seen[i];
          m_wait[i] = 0;
        end else if (!m_wait[i]) begin
          m_wait[i] = 1; m_ticks[i] = 0;
        end else if (m_tick) m_ticks[i]++;
      end
      m_q[1] = m_q[0];
      m_q[0] = in_port;
      if (chipselect && !write_n) begin
        if (address == 1) m_mask = writedata[3:0];
        if (address == 2) m_edge &= ~writedata[3:0];
        if (address == 3) m_cfg = writedata[15:0];
      end
      m_edge |= m_pressed;
    end
  end
  always @(negedge clk)
    if (mon) begin
      chk("key_level", {28'h0, key_level}, {28'h0, m_deb});
      chk("irq", {31'h0, irq}, {31'h0, |(m_edge & m_mask)});
      chk("readdata", readdata, m_rd);
    end
  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    address = a; writedata = d; chipselect = 1; write_n = 0;
    @(negedge clk);
    chipselect = 0; write_n = 1;
  endtask
  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    @(negedge clk);
    address = a;
    @(negedge clk);
    d = readdata;
  endtask
  logic [31:0] v;
  int e, t, n;
  initial begin
    repeat (3) @(negedge clk);
    chk("rst_readdata", readdata, 0);
    chk("rst_irq", {31'h0, irq}, 0);
    chk("rst_key_level", {28'h0, key_level}, 32'hF);
    reset_n = 1; mon = 1;
    rd(3, v); chk("cfg_default", v, 20);
    wr(1, 1); wr(3, 2);
    in_port[0] = 0; e = k;
    t = e + 3; while (t % TD != TD - 1) t++;
    t += TD;
    n = 0;
    do begin @(negedge clk); n++; end while (key_level[0] && n < 100);
    chk("press_cycles", n, t - e + 1);
    rd(2, v); chk("press_edge", v, 1);
    chk("press_irq", {31'h0, irq}, 1);
    in_port = 4'hF;
    repeat (20) @(negedge clk);
    rd(2, v); chk("release_edge", v, 1);
    chk("release_level", {28'h0, key_level}, 32'hF);
    wr(2, 32'hF); wr(3, 3);
    in_port[1] = 0;
    repeat (TD) @(negedge clk);
    in_port = 4'hF;
    repeat (20) @(negedge clk);
    chk("bounce_level", {28'h0, key_level}, 32'hF);
    rd(2, v); chk("bounce_edge", v, 0);
    chk("bounce_irq", {31'h0, irq}, 0);
    wr(3, 0);
    in_port = 4'hC; repeat (4) @(negedge clk);
    in_port = 4'hF; repeat (4) @(negedge clk);
    rd(2, v); chk("race_pre_edge", v, 3);
    in_port[0] = 0;
    @(negedge clk); @(negedge clk);
    address = 2; writedata = 3; chipselect = 1; write_n = 0;
    @(negedge clk);
    chipselect = 0; write_n = 1;
    rd(2, v); chk("race_edge", v, 1);
    in_port = 4'hF; repeat (4) @(negedge clk);
    in_port[2] = 0;
    @(negedge clk); @(negedge clk);
    chk("bypass_early", {31'h0, key_level[2]}, 1);
    @(negedge clk);
    chk("bypass_3clk", {31'h0, key_level[2]}, 0);
    in_port = 4'hF; repeat (4) @(negedge clk);
    wr(2, 32'hF); wr(3, 5);
    in_port[3] = 0;
    repeat (3 + 2 * TD) @(negedge clk);
    mon = 0; reset_n = 0; address = 2;
    repeat (2) @(negedge clk);
    reset_n = 1; mon = 1;
    n = 0;
    do begin
      @(negedge clk); n++;
      if (n == 1) begin
        chk("mid_rst_edge", readdata, 0);
        chk("mid_rst_level", {28'h0, key_level}, 32'hF);
      end
    end while (key_level[3] && n < 200);
    chk("redebounce_cycles", n, 3 + 19 * TD + 1);
    in_port = 4'hF;
    repeat (100) @(negedge clk);
    wr(3, 1);
    for (int i = 0; i < 800; i++) begin
      @(negedge clk);
      chipselect = 0; write_n = 1;
      address = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) begin
        t = $urandom_range(0, 3);
        in_port[t] = ~in_port[t];
      end
      if ($urandom_range(0, 15) == 0) begin
        chipselect = 1; write_n = 0;
        writedata = address == 3 ? 32'($urandom_range(0, 3)) : $urandom;
      end else if ($urandom_range(0, 15) == 0) write_n = 0;
      else chipselect = 1'($urandom_range(0, 1));
    end
    repeat (5) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
